// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared period counter, double-buffered
// per-channel duty values and run-time selectable edge/centre-aligned counting.
module pwm_multi_channel #(
    parameter int unsigned CH     = 4,
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned PERIOD = 10000,
    localparam int unsigned ChW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             wr_en,
    input  logic [ChW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_duty,
    output logic [CH-1:0]    pwm,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] PerW  = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] PerM1 = WIDTH'(PERIOD - 1);

    typedef enum logic {
        DirUp,
        DirDown
    } dir_e;

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    dir_e                      dir_q, dir_d;
    logic [CH-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [CH-1:0][WIDTH-1:0]  active_q, active_d;
    logic                      smode_q, smode_d;
    logic                      amode_q, amode_d;
    logic [CH-1:0]             pwm_q, pwm_d;
    logic                      ps_q, ps_d;
    logic [CH-1:0][WIDTH-1:0]  clamp_duty;
    logic                      boundary;

    // Clamp each active duty to PERIOD so the centre threshold never underflows.
    always_comb begin
        for (int i = 0; i < int'(CH); i++) begin
            clamp_duty[i] = (active_q[i] >= PerW) ? PerW : active_q[i];
        end
    end

    // Next-state: counter/direction, shadow writes, active loading, compare outputs.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        shadow_d = shadow_q;
        active_d = active_q;
        smode_d  = mode;
        amode_d  = amode_q;
        pwm_d    = '0;
        ps_d     = 1'b0;

        // Last edge of the current period: the next cnt is the first 0 of a new period.
        boundary = amode_q ? (dir_q == DirDown && cnt_q == '0) : (cnt_q == PerM1);

        if (!en) begin
            // Parked: keep the active set tracking the shadows so a restart uses fresh values.
            cnt_d    = '0;
            dir_d    = DirUp;
            active_d = shadow_q;
            amode_d  = smode_q;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                pwm_d[i] = amode_q ? (cnt_q >= PerW - clamp_duty[i]) : (cnt_q < clamp_duty[i]);
            end
            // cnt==0 going up only occurs at the start of a period in either mode.
            ps_d = (cnt_q == '0) && (dir_q == DirUp);

            if (boundary) begin
                cnt_d    = '0;
                dir_d    = DirUp;
                active_d = shadow_q;
                amode_d  = smode_q;
            end else if (!amode_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dir_q == DirUp) begin
                // Hold the top count one extra cycle while turning around.
                if (cnt_q == PerM1) begin
                    dir_d = DirDown;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Shadow write after the active load above, so a boundary write waits a period.
        if (wr_en && (32'(wr_ch) < CH)) begin
            shadow_d[wr_ch] = wr_duty;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            dir_q    <= DirUp;
            shadow_q <= '0;
            active_q <= '0;
            smode_q  <= 1'b0;
            amode_q  <= 1'b0;
            pwm_q    <= '0;
            ps_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            smode_q  <= smode_d;
            amode_q  <= amode_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: table vectors, directed corner
// sequences and randomized traffic against a phase-based reference model.
module tb_pwm_multi_channel;

    localparam int unsigned CH     = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned PERIOD = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             mode;
    logic             wr_en;
    logic [1:0]       wr_ch;
    logic [WIDTH-1:0] wr_duty;
    logic [CH-1:0]    pwm;
    logic             period_start;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .CH     (CH),
        .WIDTH  (WIDTH),
        .PERIOD (PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm          (pwm),
        .period_start (period_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the period, not a counter/direction pair.
    int            m_shadow[CH];
    int            m_active[CH];
    bit            m_smode, m_amode;
    int            m_pos;
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;

    // Edge: high for the first D positions. Centre: high for the D positions either side
    // of the turnaround between positions PERIOD-1 and PERIOD.
    function automatic bit m_high(input int duty, input bit centre, input int pos);
        int d;
        d = (duty > int'(PERIOD)) ? int'(PERIOD) : duty;
        if (!centre) return pos < d;
        return (pos >= int'(PERIOD) - d) && (pos < int'(PERIOD) + d);
    endfunction

    task automatic model_step();
        int old_sh[CH];
        bit old_sm;
        int len;
        if (rst) begin
            for (int i = 0; i < int'(CH); i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_smode = 0;
            m_amode = 0;
            m_pos   = 0;
            exp_pwm = '0;
            exp_ps  = 1'b0;
        end else begin
            old_sh = m_shadow;
            old_sm = m_smode;
            if (!en) begin
                exp_pwm  = '0;
                exp_ps   = 1'b0;
                m_pos    = 0;
                m_active = old_sh;
                m_amode  = old_sm;
            end else begin
                len = m_amode ? 2 * int'(PERIOD) : int'(PERIOD);
                for (int i = 0; i < int'(CH); i++) exp_pwm[i] = m_high(m_active[i], m_amode, m_pos);
                exp_ps = (m_pos == 0);
                m_pos++;
                if (m_pos == len) begin
                    m_pos    = 0;
                    m_active = old_sh;
                    m_amode  = old_sm;
                end
            end
            if (wr_en) m_shadow[wr_ch] = int'(wr_duty);
            m_smode = mode;
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pwm_model", int'(pwm), int'(exp_pwm));
        check("ps_model", int'(period_start), int'(exp_ps));
    endtask

    task automatic tick_wr(input int ch, input int duty);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = WIDTH'(duty);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        wr_en = 1'b0;
        tick();
        check("reset_pwm", int'(pwm), 0);
        check("reset_ps", int'(period_start), 0);
        tick();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic             mode;
        logic [3:0][7:0]  duty;
        logic [3:0][7:0]  exp_hi;
    } vec_t;

    function automatic vec_t mk(input bit m, input int d0, input int d1, input int d2,
                                input int d3, input int e0, input int e1, input int e2,
                                input int e3);
        vec_t v;
        v.mode      = m;
        v.duty[0]   = 8'(d0);
        v.duty[1]   = 8'(d1);
        v.duty[2]   = 8'(d2);
        v.duty[3]   = 8'(d3);
        v.exp_hi[0] = 8'(e0);
        v.exp_hi[1] = 8'(e1);
        v.exp_hi[2] = 8'(e2);
        v.exp_hi[3] = 8'(e3);
        return v;
    endfunction

    initial begin
        vec_t vecs[5];
        int   hi[CH];
        int   ps_cnt;
        int   len;
        int   cnt1;
        int   first_hi;

        // High cycles per period for each channel, derived by hand.
        vecs[0] = mk(1'b0, 0, 0, 0, 0,      0, 0, 0, 0);
        vecs[1] = mk(1'b0, 0, 3, 10, 200,   0, 3, 10, 10);
        vecs[2] = mk(1'b1, 4, 0, 10, 1,     8, 0, 20, 2);
        vecs[3] = mk(1'b1, 200, 9, 5, 2,    20, 18, 10, 4);
        vecs[4] = mk(1'b0, 1, 9, 5, 7,      1, 9, 5, 7);

        rst = 1'b1; en = 1'b0; mode = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;

        // Table vectors: two full periods after enabling.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int c = 0; c < int'(CH); c++) tick_wr(c, int'(vecs[v].duty[c]));
            mode = vecs[v].mode;
            repeat (3) tick();
            en = 1'b1;
            len = vecs[v].mode ? 2 * int'(PERIOD) : int'(PERIOD);
            for (int c = 0; c < int'(CH); c++) hi[c] = 0;
            ps_cnt = 0;
            for (int k = 0; k < 2 * len; k++) begin
                tick();
                if (k == 0) check("vec_first_ps", int'(period_start), 1);
                for (int c = 0; c < int'(CH); c++) hi[c] += int'(pwm[c]);
                ps_cnt += int'(period_start);
            end
            for (int c = 0; c < int'(CH); c++) check("vec_high_count", hi[c], 2 * int'(vecs[v].exp_hi[c]));
            check("vec_ps_count", ps_cnt, 2);
        end

        // Mid-period write and boundary-cycle write on ch1.
        do_reset();
        tick_wr(1, 3);
        repeat (2) tick();
        en = 1'b1;
        cnt1 = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) tick_wr(1, 7); else tick();
            cnt1 += int'(pwm[1]);
        end
        check("midwrite_current", cnt1, 3);
        cnt1 = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) tick_wr(1, 2); else tick();
            cnt1 += int'(pwm[1]);
        end
        check("midwrite_next", cnt1, 7);
        cnt1 = 0;
        for (int k = 1; k <= 10; k++) begin tick(); cnt1 += int'(pwm[1]); end
        check("boundary_write_deferred", cnt1, 7);
        cnt1 = 0;
        for (int k = 1; k <= 10; k++) begin tick(); cnt1 += int'(pwm[1]); end
        check("boundary_write_applied", cnt1, 2);

        // Mode change mid-period switches at the boundary only.
        do_reset();
        tick_wr(0, 4);
        repeat (2) tick();
        en = 1'b1;
        ps_cnt = 0; cnt1 = 0; first_hi = 0;
        for (int k = 1; k <= 31; k++) begin
            if (k == 3) mode = 1'b1;
            tick();
            if (k == 11) check("mode_ps_edge_end", int'(period_start), 1);
            if (k == 31) check("mode_ps_centre_end", int'(period_start), 1);
            if (k > 11 && k < 31) ps_cnt += int'(period_start);
            if (k >= 11 && k <= 30) begin
                cnt1 += int'(pwm[0]);
                if (pwm[0] && first_hi == 0) first_hi = k;
            end
        end
        check("mode_centre_no_ps", ps_cnt, 0);
        check("mode_centre_high", cnt1, 8);
        check("mode_centre_first_high", first_hi, 17);

        // en dropped at cnt=5, then re-raised with new shadow duty.
        do_reset();
        for (int c = 0; c < int'(CH); c++) tick_wr(c, 10);
        repeat (2) tick();
        en = 1'b1;
        repeat (5) tick();
        check("en_before_drop", int'(pwm), 15);
        en = 1'b0;
        tick();
        check("en_drop_pwm", int'(pwm), 0);
        tick_wr(0, 2);
        repeat (2) tick();
        en = 1'b1;
        tick();
        check("en_restart_ps", int'(period_start), 1);
        check("en_restart_pwm", int'(pwm), 15);
        cnt1 = int'(pwm[0]);
        for (int k = 2; k <= 10; k++) begin tick(); cnt1 += int'(pwm[0]); end
        check("en_restart_ch0", cnt1, 2);

        // Reset mid-pulse with a same-cycle write.
        do_reset();
        tick_wr(0, 5);
        repeat (2) tick();
        en = 1'b1;
        repeat (2) tick();
        check("rst_pre_high", int'(pwm[0]), 1);
        rst = 1'b1;
        tick_wr(0, 9);
        check("rst_pwm", int'(pwm), 0);
        check("rst_ps", int'(period_start), 0);
        rst = 1'b0;
        cnt1 = 0; ps_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cnt1 += int'(pwm[0]);
            ps_cnt += int'(period_start);
        end
        check("rst_write_lost", cnt1, 0);
        check("rst_ps_count", ps_cnt, 2);

        // Randomized traffic against the model.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            wr_en   = ($urandom_range(3) == 0);
            wr_ch   = 2'($urandom_range(3));
            wr_duty = WIDTH'($urandom_range(13));
            if ($urandom_range(49) == 0) mode = ~mode;
            if ($urandom_range(99) == 0) en = ~en;
            rst = ($urandom_range(499) == 0);
            tick();
        end
        wr_en = 1'b0;
        rst   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
